// File: rtl/smart_mac_mc.sv
// smart_mac_mc: systolic MAC cell with weight/output-stationary modes and smart-bus bypass.
module smart_mac_mc #(
   parameter int WORD_SIZE = 16,
   parameter int NUM_CH    = 2,
   parameter int ACC_GUARD = 8,
   localparam int ACC_W    = 2*WORD_SIZE+ACC_GUARD,
   localparam int CH_W     = $clog2(NUM_CH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          mode_in,
   input  logic                          start_in,
   input  logic                          valid_in,
   input  logic                          last_in,
   input  logic                          load_w_in,
   input  logic                          select_left_in_smart,
   input  logic                          select_top_in_smart,
   input  logic [CH_W-1:0]               left_ch_sel,
   input  logic [CH_W-1:0]               top_ch_sel,
   input  logic                          select_right_out_smart,
   input  logic                          select_bottom_out_smart,
   input  logic [CH_W-1:0]               right_ch_sel,
   input  logic [CH_W-1:0]               bottom_ch_sel,
   input  logic [WORD_SIZE-1:0]          left_in,
   input  logic [WORD_SIZE-1:0]          top_in,
   output logic [WORD_SIZE-1:0]          right_out,
   output logic [WORD_SIZE-1:0]          bottom_out,
   output logic                          valid_out,
   output logic                          busy_out,
   output logic                          done_out,
   input  logic [NUM_CH*WORD_SIZE-1:0]   horizontal_smart_bus_in,
   input  logic [NUM_CH*WORD_SIZE-1:0]   vertical_smart_bus_in,
   output logic [NUM_CH*WORD_SIZE-1:0]   horizontal_smart_bus_out,
   output logic [NUM_CH*WORD_SIZE-1:0]   vertical_smart_bus_out
);
   typedef enum logic [1:0] {IDLE, COMPUTE, DRAIN} state_t;
   localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-WORD_SIZE+1){1'b0}}, {(WORD_SIZE-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-WORD_SIZE+1){1'b1}}, {(WORD_SIZE-1){1'b0}}};
   state_t state;
   logic mode, done_pend;
   logic signed [ACC_W-1:0] acc, l_x, t_x, w_x, ws_sum, acc_nxt;
   logic signed [WORD_SIZE-1:0] weight, left_op, top_op;
   logic [WORD_SIZE-1:0] left_bus, top_bus;

   function automatic logic [WORD_SIZE-1:0] sat(input logic signed [ACC_W-1:0] x);
      return x > SMAX ? SMAX[WORD_SIZE-1:0] : x < SMIN ? SMIN[WORD_SIZE-1:0] : x[WORD_SIZE-1:0];
   endfunction

   // unmatched (out-of-range) channel selects read zero and inject nothing
   always_comb begin
      left_bus = '0;
      top_bus = '0;
      horizontal_smart_bus_out = horizontal_smart_bus_in;
      vertical_smart_bus_out = vertical_smart_bus_in;
      for (int k = 0; k < NUM_CH; k++) begin
         if (left_ch_sel == CH_W'(k)) left_bus = horizontal_smart_bus_in[k*WORD_SIZE +: WORD_SIZE];
         if (top_ch_sel == CH_W'(k)) top_bus = vertical_smart_bus_in[k*WORD_SIZE +: WORD_SIZE];
         if (select_right_out_smart && right_ch_sel == CH_W'(k))
            horizontal_smart_bus_out[k*WORD_SIZE +: WORD_SIZE] = right_out;
         if (select_bottom_out_smart && bottom_ch_sel == CH_W'(k))
            vertical_smart_bus_out[k*WORD_SIZE +: WORD_SIZE] = bottom_out;
      end
   end

   assign left_op  = select_left_in_smart ? left_bus : left_in;
   assign top_op   = select_top_in_smart ? top_bus : top_in;
   assign l_x      = ACC_W'(left_op);
   assign t_x      = ACC_W'(top_op);
   assign w_x      = ACC_W'(weight);
   assign ws_sum   = t_x + l_x * w_x;
   assign acc_nxt  = acc + l_x * t_x;
   assign busy_out = state != IDLE;

   // WS completion is deferred one cycle so done follows the final output beat
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         state <= IDLE;
         mode <= 1'b0;
         done_pend <= 1'b0;
         acc <= '0;
         weight <= '0;
         right_out <= '0;
         bottom_out <= '0;
         valid_out <= 1'b0;
         done_out <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         done_out <= 1'b0;
         case (state)
            IDLE: begin
               done_out <= done_pend;
               done_pend <= 1'b0;
               if (load_w_in) weight <= top_op;
               if (start_in) begin
                  state <= COMPUTE;
                  mode <= mode_in;
                  acc <= '0;
               end
            end
            COMPUTE: if (valid_in) begin
               right_out <= left_op;
               valid_out <= 1'b1;
               if (mode) begin
                  acc <= acc_nxt;
                  bottom_out <= top_op;
               end else bottom_out <= sat(ws_sum);
               if (last_in) begin
                  state <= mode ? DRAIN : IDLE;
                  done_pend <= !mode;
               end
            end
            DRAIN: begin
               bottom_out <= sat(acc);
               valid_out <= 1'b1;
               done_out <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_smart_mac_mc.sv
// tb_smart_mac_mc: directed self-checking bench for smart_mac_mc (WORD_SIZE=16, NUM_CH=2).
module tb_smart_mac_mc;
   logic clk = 0, rst = 0;
   logic mode_in = 0, start_in = 0, valid_in = 0, last_in = 0, load_w_in = 0;
   logic select_left_in_smart = 0, select_top_in_smart = 0;
   logic left_ch_sel = 0, top_ch_sel = 0;
   logic select_right_out_smart = 0, select_bottom_out_smart = 0;
   logic right_ch_sel = 0, bottom_ch_sel = 0;
   logic [15:0] left_in = 0, top_in = 0, right_out, bottom_out;
   logic valid_out, busy_out, done_out;
   logic [31:0] h_in = 0, v_in = 0, h_out, v_out;
   int checks = 0, errors = 0;

   smart_mac_mc #(.WORD_SIZE(16), .NUM_CH(2), .ACC_GUARD(8)) dut (
      .clk(clk), .rst(rst), .mode_in(mode_in), .start_in(start_in), .valid_in(valid_in),
      .last_in(last_in), .load_w_in(load_w_in),
      .select_left_in_smart(select_left_in_smart), .select_top_in_smart(select_top_in_smart),
      .left_ch_sel(left_ch_sel), .top_ch_sel(top_ch_sel),
      .select_right_out_smart(select_right_out_smart), .select_bottom_out_smart(select_bottom_out_smart),
      .right_ch_sel(right_ch_sel), .bottom_ch_sel(bottom_ch_sel),
      .left_in(left_in), .top_in(top_in), .right_out(right_out), .bottom_out(bottom_out),
      .valid_out(valid_out), .busy_out(busy_out), .done_out(done_out),
      .horizontal_smart_bus_in(h_in), .vertical_smart_bus_in(v_in),
      .horizontal_smart_bus_out(h_out), .vertical_smart_bus_out(v_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_w(input int w);
      top_in = 16'(w);
      load_w_in = 1;
      tick();
      load_w_in = 0;
      top_in = 0;
   endtask

   task automatic start(input logic m);
      mode_in = m;
      start_in = 1;
      tick();
      start_in = 0;
      mode_in = 0;
   endtask

   task automatic beat(input int l, input int t, input logic lst);
      left_in = 16'(l);
      top_in = 16'(t);
      valid_in = 1;
      last_in = lst;
      tick();
      valid_in = 0;
      last_in = 0;
   endtask

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      h_in = {16'd11, 16'd22};
      v_in = {16'd33, 16'd44};
      tick();
      tick();
      check("rst_bottom", $signed(bottom_out), 0);
      check("rst_right", $signed(right_out), 0);
      check("rst_busy", busy_out, 0);
      check("rst_valid", valid_out, 0);
      check("rst_done", done_out, 0);
      check("rst_hbus", h_out, {16'd11, 16'd22});
      rst = 1;
      tick();
      // weight-stationary single beat
      load_w(3);
      start(0);
      check("ws_busy", busy_out, 1);
      beat(5, 10, 1);
      check("ws_bottom", $signed(bottom_out), 25);
      check("ws_right", $signed(right_out), 5);
      check("ws_valid", valid_out, 1);
      check("ws_done_early", done_out, 0);
      tick();
      check("ws_done", done_out, 1);
      check("ws_valid_off", valid_out, 0);
      tick();
      check("ws_done_off", done_out, 0);
      // output-stationary three beats
      start(1);
      beat(2, 3, 0);
      check("os_pass", $signed(bottom_out), 3);
      beat(4, -5, 0);
      beat(7, 1, 1);
      check("os_drain_busy", busy_out, 1);
      tick();
      check("os_bottom", $signed(bottom_out), -7);
      check("os_valid", valid_out, 1);
      check("os_done", done_out, 1);
      check("os_idle", busy_out, 0);
      tick();
      check("os_done_off", done_out, 0);
      check("os_busy_off", busy_out, 0);
      // saturation
      start(1);
      beat(32767, 32767, 0);
      beat(32767, 32767, 1);
      tick();
      check("os_sat", $signed(bottom_out), 32767);
      tick();
      load_w(3);
      start(0);
      beat(-32768, 0, 1);
      check("ws_sat", $signed(bottom_out), -32768);
      tick();
      // smart bus
      load_w(2);
      start(0);
      h_in = {16'd9, 16'd100};
      v_in = {16'd7, 16'd8};
      select_left_in_smart = 1;
      left_ch_sel = 1;
      beat(4, 0, 1);
      check("sb_right", $signed(right_out), 9);
      check("sb_bottom", $signed(bottom_out), 18);
      select_right_out_smart = 1;
      right_ch_sel = 0;
      select_bottom_out_smart = 1;
      bottom_ch_sel = 1;
      #1;
      check("sb_h0_inj", $signed(h_out[15:0]), 9);
      check("sb_h1_pass", $signed(h_out[31:16]), 9);
      check("sb_v1_inj", $signed(v_out[31:16]), 18);
      check("sb_v0_pass", $signed(v_out[15:0]), 8);
      select_top_in_smart = 1;
      top_ch_sel = 0;
      load_w_in = 1;
      tick();
      load_w_in = 0;
      select_top_in_smart = 0;
      select_left_in_smart = 0;
      select_right_out_smart = 0;
      select_bottom_out_smart = 0;
      // weight now 8 from vertical channel 0
      start(0);
      beat(1, 1, 1);
      check("sb_top_w", $signed(bottom_out), 9);
      tick();
      // reset mid-OS
      start(1);
      beat(5, 5, 0);
      beat(6, 6, 0);
      rst = 0;
      select_right_out_smart = 1;
      right_ch_sel = 0;
      #1;
      check("mrst_busy", busy_out, 0);
      check("mrst_bottom", $signed(bottom_out), 0);
      check("mrst_valid", valid_out, 0);
      check("mrst_h0", $signed(h_out[15:0]), 0);
      tick();
      rst = 1;
      select_right_out_smart = 0;
      tick();
      start(1);
      beat(1, 1, 1);
      tick();
      check("mrst_fresh", $signed(bottom_out), 1);
      tick();
      // ignored controls while busy and valid in IDLE
      load_w(3);
      start(0);
      start_in = 1;
      load_w_in = 1;
      mode_in = 1;
      top_in = 50;
      tick();
      start_in = 0;
      load_w_in = 0;
      mode_in = 0;
      check("ign_busy", busy_out, 1);
      check("ign_valid", valid_out, 0);
      beat(2, 1, 1);
      check("ign_weight", $signed(bottom_out), 7);
      check("ign_mode", busy_out, 0);
      tick();
      check("ign_done", done_out, 1);
      left_in = 8;
      valid_in = 1;
      tick();
      tick();
      valid_in = 0;
      check("idle_valid", valid_out, 0);
      check("idle_right", $signed(right_out), 2);
      check("idle_busy", busy_out, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
